// File: rtl/io_manager_p.sv
// Memory-mapped I/O manager: 8-word I/O window, synchronised switches, debounced buttons with sticky press flags, output registers.
// Optional interrupt mask and registered irq output are enabled by defining IOM_IRQ_EN.
module io_manager_p #(
  parameter logic [15:0] IO_BASE         = 16'hFFF8,
  parameter int          SW_W            = 10,
  parameter int          BTN_W           = 4,
  parameter int          OUT_W           = 10,
  parameter int          NUM_OUT         = 2,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     oe_cpu,
  input  logic [15:0]              addr,
  input  logic [BTN_W-1:0]         buttons,
  input  logic [SW_W-1:0]          switches,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  output logic [4:0]               control_mem,
  output logic                     irq,
  inout  wire  [15:0]              data
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             io_hit;
  logic [2:0]       off;
  logic             wr_en;
  logic [15:0]      rd_val;
  logic             unused_data;

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [BTN_W-1:0] btn_in;

  logic [BTN_W-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [BTN_W];
  logic [CNT_W-1:0] cnt_d [BTN_W];
  logic [BTN_W-1:0] flag_q, flag_d;
  logic [BTN_W-1:0] clr;
  logic [OUT_W-1:0] out_q [NUM_OUT];
  logic [OUT_W-1:0] out_d [NUM_OUT];

  assign io_hit      = (addr[15:3] == IO_BASE[15:3]);
  assign off         = addr[2:0];
  assign wr_en       = io_hit & oe_cpu;
  assign btn_in      = ~btn_s2_q;
  assign unused_data = ^data;

  always_comb begin
    if (io_hit)      control_mem = 5'b11111;
    else if (oe_cpu) control_mem = 5'b00100;
    else             control_mem = 5'b10000;
  end

  // Debounce: level toggles only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < BTN_W; i++) begin
      if (btn_in[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = ~lvl_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // A new press in the same cycle as a clear-write keeps the flag set
  always_comb begin
    clr    = (wr_en && off == 3'd2) ? data[BTN_W-1:0] : '0;
    flag_d = (flag_q & ~clr) | (lvl_d & ~lvl_q);
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_en && off == 3'(4 + k)) out_d[k] = data[OUT_W-1:0];
    end
  end

  always_comb begin
    out_regs = '0;
    for (int k = 0; k < NUM_OUT; k++) out_regs[k*OUT_W +: OUT_W] = out_q[k];
  end

`ifdef IOM_IRQ_EN
  logic [BTN_W-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    mask_d = (wr_en && off == 3'd3) ? data[BTN_W-1:0] : mask_q;
    irq_d  = |(flag_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      3'd0: rd_val[SW_W-1:0]  = sw_s2_q;
      3'd1: rd_val[BTN_W-1:0] = lvl_q;
      3'd2: rd_val[BTN_W-1:0] = flag_q;
`ifdef IOM_IRQ_EN
      3'd3: rd_val[BTN_W-1:0] = mask_q;
`endif
      default: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (off == 3'(4 + k)) rd_val[OUT_W-1:0] = out_q[k];
        end
      end
    endcase
  end

  assign data = (io_hit && !oe_cpu) ? rd_val : 16'hzzzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
      lvl_q    <= '0;
      flag_q   <= '0;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      sw_s1_q  <= switches;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= buttons;
      btn_s2_q <= btn_s1_q;
      lvl_q    <= lvl_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_io_manager_p.sv
// Directed bench for io_manager_p with default parameters (SW_W=10, BTN_W=4, OUT_W=10, NUM_OUT=2, DEBOUNCE_CYCLES=4).
module tb_io_manager_p;

  localparam logic [15:0] IO_BASE = 16'hFFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        oe_cpu;
  logic [15:0] addr;
  logic [3:0]  buttons;
  logic [9:0]  switches;
  logic [19:0] out_regs;
  logic [4:0]  control_mem;
  logic        irq;
  wire  [15:0] data;
  logic        drv_en;
  logic [15:0] drv_val;

  int vectors = 0;
  int miscompares = 0;

  assign data = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  io_manager_p dut (
    .clk(clk), .reset(reset), .oe_cpu(oe_cpu), .addr(addr),
    .buttons(buttons), .switches(switches), .out_regs(out_regs),
    .control_mem(control_mem), .irq(irq), .data(data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] v);
    addr    = IO_BASE + 16'(off);
    oe_cpu  = 1'b1;
    drv_val = v;
    drv_en  = 1'b1;
    @(posedge clk);
    #1;
    drv_en = 1'b0;
    oe_cpu = 1'b0;
    addr   = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [15:0] exp);
    addr   = IO_BASE + 16'(off);
    oe_cpu = 1'b0;
    #1;
    chk(tag, 32'(data), 32'(exp));
    addr = 16'h0000;
  endtask

  initial begin
    reset = 1'b0; oe_cpu = 1'b0; addr = 16'h0000;
    buttons = 4'hF; switches = 10'h000; drv_en = 1'b0; drv_val = 16'h0000;
    tick(2);
    chk("rst_out_regs", 32'(out_regs), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    tick(3);

    for (int o = 0; o < 8; o++) begin
      addr = IO_BASE + 16'(o);
      #1;
      chk("idle_read", 32'(data), 32'h0);
      chk("io_ctrl", 32'(control_mem), 32'h1F);
    end
    addr = 16'h0000;
    tick(1);

    wr(3'd4, 16'hFFFF);
    wr(3'd5, 16'h0155);
    chk("out_regs_wr", 32'(out_regs), 32'h557FF);
    rd("rd_out0", 3'd4, 16'h03FF);
    rd("rd_out1", 3'd5, 16'h0155);
    tick(1);

    switches = 10'h2A5;
    rd("sw_lag0", 3'd0, 16'h0000);
    tick(1);
    rd("sw_lag1", 3'd0, 16'h0000);
    tick(1);
    rd("sw_lag2", 3'd0, 16'h02A5);

    // 3-cycle glitch on button 2 must be rejected
    buttons = 4'b1011;
    tick(3);
    buttons = 4'hF;
    tick(6);
    rd("glitch_lvl", 3'd1, 16'h0000);
    rd("glitch_flag", 3'd2, 16'h0000);
    tick(1);

    buttons = 4'b1011;
    tick(5);
    rd("press_lvl_early", 3'd1, 16'h0000);
    tick(1);
    rd("press_lvl", 3'd1, 16'h0004);
    rd("press_flag", 3'd2, 16'h0004);
    tick(1);
    wr(3'd2, 16'h0004);
    rd("flag_cleared", 3'd2, 16'h0000);
    rd("lvl_held", 3'd1, 16'h0004);
    buttons = 4'hF;
    tick(8);
    rd("release_lvl", 3'd1, 16'h0000);
    rd("release_noflag", 3'd2, 16'h0000);
    tick(1);

    // Level rises on the same edge as the clear-write of bit 0
    buttons = 4'b1110;
    tick(5);
    wr(3'd2, 16'h0001);
    rd("set_wins", 3'd2, 16'h0001);
    buttons = 4'hF;
    tick(8);
    wr(3'd2, 16'h0001);
    rd("flag0_cleared", 3'd2, 16'h0000);
    tick(1);

    addr = 16'h1234; oe_cpu = 1'b1; drv_val = 16'hA5A5; drv_en = 1'b1;
    #1;
    chk("sram_store_ctrl", 32'(control_mem), 32'h04);
    chk("sram_store_data", 32'(data), 32'hA5A5);
    drv_en = 1'b0; oe_cpu = 1'b0;
    #1;
    chk("sram_load_ctrl", 32'(control_mem), 32'h10);
    addr = 16'h0000;
    tick(1);

    wr(3'd0, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    rd("ro_sw", 3'd0, 16'h02A5);
    rd("unmapped6", 3'd6, 16'h0000);
    chk("out_regs_kept", 32'(out_regs), 32'h557FF);
    tick(1);

`ifdef IOM_IRQ_EN
    wr(3'd3, 16'h0001);
    rd("mask_rd", 3'd3, 16'h0001);
    buttons = 4'b1110;
    tick(5);
    chk("irq_pre", 32'(irq), 32'h0);
    tick(1);
    rd("irq_flag_set", 3'd2, 16'h0001);
    chk("irq_same_cycle", 32'(irq), 32'h0);
    tick(1);
    chk("irq_asserted", 32'(irq), 32'h1);
    buttons = 4'hF;
    tick(8);
    wr(3'd2, 16'h0001);
    chk("irq_lag", 32'(irq), 32'h1);
    tick(1);
    chk("irq_deassert", 32'(irq), 32'h0);
`else
    wr(3'd3, 16'h0001);
    rd("mask_absent", 3'd3, 16'h0000);
    buttons = 4'b1110;
    tick(7);
    rd("flag_no_irq", 3'd2, 16'h0001);
    chk("irq_tied", 32'(irq), 32'h0);
    buttons = 4'hF;
    tick(8);
`endif

    // Asynchronous reset with a write pending
    addr = IO_BASE + 16'd4; oe_cpu = 1'b1; drv_val = 16'h0123; drv_en = 1'b1;
    reset = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_regs), 32'h0);
    tick(1);
    chk("rst_write_drop", 32'(out_regs), 32'h0);
    drv_en = 1'b0; oe_cpu = 1'b0; addr = 16'h0000;
    reset = 1'b1;
    tick(3);
    rd("post_rst_flag", 3'd2, 16'h0000);
    rd("post_rst_sw", 3'd0, 16'h02A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_manager_p.md
Name: io_manager_p

Overview:
- Parametrised successor of the CPU's memory-mapped I/O manager; sits between the single-cycle CPU data bus and the board I/O and external SRAM.
- Decodes a configurable 8-word I/O window at the top of the 16-bit address space.
- Provides synchronised switches, debounced buttons with sticky press flags, and NUM_OUT read/write output registers.
- All other addresses are steered to SRAM via control_mem.

Parameters:
IO_BASE, 16'hFFF8, base of 8-word I/O window; must be 8-word aligned
SW_W, 10, switch count (1..16)
BTN_W, 4, button count (1..16)
OUT_W, 10, width of each output register (1..16)
NUM_OUT, 2, number of output registers (1..4)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button change (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
oe_cpu  input  1  1 = CPU drives data (write); 0 = CPU reads
addr  input  16  CPU address
buttons  input  BTN_W  raw push buttons, active-low at pins
switches  input  SW_W  raw slide switches
out_regs  output  NUM_OUT*OUT_W  output registers concatenated; register k at bits [k*OUT_W +: OUT_W]
control_mem  output  5  SRAM control {we, ce, oe, lb, ub}, active-low
irq  output  1  interrupt request (IOM_IRQ_EN only; otherwise tied 0)
data  inout  16  bidirectional CPU data bus

Behaviour:
- Reset (reset=0, asynchronous):
  - out_regs=0; edge flags=0; irq mask=0; irq=0; debounced levels=0; debounce counters=0.
  - Switch sync flops=0; button sync flops=all 1s (released).
- I/O hit: addr[15:3]==IO_BASE[15:3]; offset = addr[2:0].
- Address map:
  - 0: switches, read-only.
  - 1: debounced button level, active-high (1 = pressed), read-only.
  - 2: press flags; read returns flags; write-1-to-clear.
  - 3: irq mask (IOM_IRQ_EN only; otherwise reads 0, writes ignored).
  - 4..4+NUM_OUT-1: output registers, R/W.
  - Remaining offsets: read 0, writes ignored.
- Reads:
  - Combinational: when oe_cpu=0 and I/O hit, the block drives data with the selected value, zero-extended to 16 bits.
  - Otherwise data is high-Z from this block.
- Writes:
  - When oe_cpu=1 and I/O hit, the target is updated at the next rising clk from data, truncated to the target width.
  - Write data is sampled from the data pin.
- control_mem:
  - I/O hit: 5'b11111 (SRAM deselected).
  - Non-hit with oe_cpu=1 (store): 5'b00100.
  - Non-hit with oe_cpu=0 (load): 5'b10000.
  - Purely combinational.
- Input synchronisation:
  - Switches and buttons each pass through 2 flops; switch read value lags the pins by 2 cycles.
- Debounce, per button, on the inverted synchronised input:
  - If it differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the level toggles and the counter clears.
  - Net latency from a pin change to the level change: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no level change.
- Press flags:
  - A flag sets on a debounced 0->1 transition and holds until cleared.
  - If set and clear occur in the same cycle, set wins.
  - Release (1->0) does not set a flag.
- Simultaneous events: different registers update independently in the same cycle; a write to a read-only offset has no effect.
- Reset mid-operation: all state returns to reset values immediately; a pending write is discarded.

Optional Feature:
Macro IOM_IRQ_EN.
- Defined:
  - Offset 3 is a BTN_W-bit R/W mask.
  - irq is registered: irq <= |(flags & mask), one cycle after the flag/mask state.
  - irq deasserts one cycle after the last masked flag is cleared or masked off.
- Not defined:
  - No mask register; offset 3 reads 0.
  - irq is constant 0.

Test Plan:
- Reset, then reads of offsets 0-7 with switches=0 and buttons released -> all read 16'h0000; out_regs=0; control_mem=5'b11111 on each I/O access.
- Write 16'hFFFF to offset 4 and 16'h0155 to offset 5 (OUT_W=10) -> out_regs={10'h155,10'h3FF}; read-back of offset 4 returns 16'h03FF.
- Switches set to 10'h2A5 -> offset 0 reads 16'h02A5 from the 2nd cycle after the change, not earlier.
- Button 2 pressed for 3 cycles then released -> no level change and flags=0. Button 2 held low for 6 cycles -> level bit 2 set at cycle 2+4; flag reads 16'h0004; write 16'h0004 to offset 2 -> flag clears.
- Same cycle: new press on button 0 plus clear-write of bit 0 -> flag bit 0 remains 1.
- Non-I/O address 16'h1234: oe_cpu=1 -> control_mem=5'b00100 and data not driven by the block; oe_cpu=0 -> control_mem=5'b10000. With IOM_IRQ_EN: mask=4'b0001 and button 0 press -> irq=1 one cycle after the flag sets; clear the flag -> irq=0 one cycle later.
